// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded instructions, forwards
// EX/MEM and MEM/WB results into the operands, and keeps held operands fresh while stalled.
module idex_operand_stage #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [15:0]       id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_alusrc,
  input  logic [1:0]        id_extop,
  input  logic              id_shift,
  input  logic [3:0]        id_aluop,
  input  logic              id_regwen,
  input  logic [REG_AW-1:0] id_wsel,
  input  logic              exmem_wen,
  input  logic [REG_AW-1:0] exmem_wsel,
  input  logic [WORD_W-1:0] exmem_data,
  input  logic              memwb_wen,
  input  logic [REG_AW-1:0] memwb_wsel,
  input  logic [WORD_W-1:0] memwb_data,
  output logic              ex_valid,
  output logic [WORD_W-1:0] ex_portA,
  output logic [WORD_W-1:0] ex_portB,
  output logic [3:0]        ex_aluop,
  output logic [WORD_W-1:0] ex_store,
  output logic              ex_regwen,
  output logic [REG_AW-1:0] ex_wsel
);

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10
  } extop_t;

  // Register index 0 reads as zero and is never a forwarding target.
  function automatic logic [WORD_W-1:0] fwd(input logic [REG_AW-1:0] idx,
                                            input logic [WORD_W-1:0] fallback);
    if (idx == '0)                              return '0;
    else if (exmem_wen && exmem_wsel == idx)    return exmem_data;
    else if (memwb_wen && memwb_wsel == idx)    return memwb_data;
    else                                        return fallback;
  endfunction

  // Held state: operands plus what is needed to re-forward them while stalled.
  logic [REG_AW-1:0] rs_q, rt_q;
  logic              a_is_reg_q, b_is_reg_q;

  logic [WORD_W-1:0] fwd_rs, fwd_rt, ext_imm, form_a, form_b;
  logic [WORD_W-1:0] snoop_a, snoop_b, snoop_store;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ext_imm = WORD_W'(id_imm);
    case (id_extop)
      EXT_SIGN: ext_imm = WORD_W'($signed(id_imm));
      EXT_LUI:  ext_imm = WORD_W'(id_imm) << 16;
      default:  ext_imm = WORD_W'(id_imm);
    endcase
  end

  always_comb begin
    fwd_rs      = fwd(id_rs, id_rdat1);
    fwd_rt      = fwd(id_rt, id_rdat2);
    form_a      = id_shift  ? WORD_W'(id_shamt) : fwd_rs;
    form_b      = id_alusrc ? ext_imm           : fwd_rt;
    snoop_a     = fwd(rs_q, ex_portA);
    snoop_b     = fwd(rt_q, ex_portB);
    snoop_store = fwd(rt_q, ex_store);
  end

  // NOTE: sequential state uses non-blocking assignments so all fields update from pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_valid   <= 1'b0;
      ex_regwen  <= 1'b0;
      ex_wsel    <= '0;
      ex_aluop   <= '0;
      ex_portA   <= '0;
      ex_portB   <= '0;
      ex_store   <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      a_is_reg_q <= 1'b0;
      b_is_reg_q <= 1'b0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      ex_regwen <= 1'b0;
    end else if (stall) begin
      if (ex_valid) begin
        if (a_is_reg_q) ex_portA <= snoop_a;
        if (b_is_reg_q) ex_portB <= snoop_b;
        ex_store <= snoop_store;
      end
    end else begin
      ex_valid   <= id_valid;
      ex_regwen  <= id_regwen & id_valid;
      ex_wsel    <= id_wsel;
      ex_aluop   <= id_aluop;
      ex_portA   <= form_a;
      ex_portB   <= form_b;
      ex_store   <= fwd_rt;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      a_is_reg_q <= ~id_shift;
      b_is_reg_q <= ~id_alusrc;
    end
  end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Self-checking bench for idex_operand_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX slot.
module tb_idex_operand_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] id_rdat1, id_rdat2;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt;
  logic        id_alusrc;
  logic [1:0]  id_extop;
  logic        id_shift;
  logic [3:0]  id_aluop;
  logic        id_regwen;
  logic [4:0]  id_wsel;
  logic        exmem_wen, memwb_wen;
  logic [4:0]  exmem_wsel, memwb_wsel;
  logic [31:0] exmem_data, memwb_data;
  logic        ex_valid, ex_regwen;
  logic [31:0] ex_portA, ex_portB, ex_store;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_wsel;

  int errors = 0;
  int checks = 0;

  idex_operand_stage #(.WORD_W(32), .REG_AW(5)) dut (
    .CLK(CLK), .nRST(nRST), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alusrc(id_alusrc), .id_extop(id_extop),
    .id_shift(id_shift), .id_aluop(id_aluop), .id_regwen(id_regwen),
    .id_wsel(id_wsel),
    .exmem_wen(exmem_wen), .exmem_wsel(exmem_wsel), .exmem_data(exmem_data),
    .memwb_wen(memwb_wen), .memwb_wsel(memwb_wsel), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_portA(ex_portA), .ex_portB(ex_portB),
    .ex_aluop(ex_aluop), .ex_store(ex_store), .ex_regwen(ex_regwen),
    .ex_wsel(ex_wsel)
  );

  always #5 CLK = ~CLK;

  // Model of what the EX slot should hold, expressed as the instruction it carries.
  typedef struct {
    bit        valid, regwen;
    bit [4:0]  wsel;
    bit [3:0]  aluop;
    bit [31:0] porta, portb, store;
    bit [4:0]  rs, rt;
    bit        a_from_reg, b_from_reg;
  } slot_t;

  slot_t m;

  function automatic bit [31:0] ref_value(input bit [4:0] r, input bit [31:0] otherwise);
    if (r == 0) return 32'd0;
    if (exmem_wen && exmem_wsel == r) return exmem_data;
    if (memwb_wen && memwb_wsel == r) return memwb_data;
    return otherwise;
  endfunction

  function automatic bit [31:0] ref_ext();
    bit [31:0] v;
    case (id_extop)
      2'b01:   v = {{16{id_imm[15]}}, id_imm};
      2'b10:   v = {id_imm, 16'h0000};
      default: v = {16'h0000, id_imm};
    endcase
    return v;
  endfunction

  function automatic slot_t model_next(input slot_t cur);
    slot_t n = cur;
    if (flush) begin
      n.valid  = 0;
      n.regwen = 0;
    end else if (stall) begin
      if (cur.valid) begin
        if (cur.a_from_reg) n.porta = ref_value(cur.rs, cur.porta);
        if (cur.b_from_reg) n.portb = ref_value(cur.rt, cur.portb);
        n.store = ref_value(cur.rt, cur.store);
      end
    end else begin
      n.valid      = id_valid;
      n.regwen     = id_regwen && id_valid;
      n.wsel       = id_wsel;
      n.aluop      = id_aluop;
      n.porta      = id_shift ? {27'd0, id_shamt} : ref_value(id_rs, id_rdat1);
      n.portb      = id_alusrc ? ref_ext() : ref_value(id_rt, id_rdat2);
      n.store      = ref_value(id_rt, id_rdat2);
      n.rs         = id_rs;
      n.rt         = id_rt;
      n.a_from_reg = !id_shift;
      n.b_from_reg = !id_alusrc;
    end
    return n;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) m <= '{default: 0};
    else       m <= model_next(m);
  end

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0;
    id_rdat1 = 0; id_rdat2 = 0; id_imm = 0; id_shamt = 0; id_alusrc = 0;
    id_extop = 0; id_shift = 0; id_aluop = 0; id_regwen = 0; id_wsel = 0;
    exmem_wen = 0; exmem_wsel = 0; exmem_data = 0;
    memwb_wen = 0; memwb_wsel = 0; memwb_data = 0;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 0;
    idle_inputs();
    tick();
    checks++;
    if ({ex_valid, ex_regwen, ex_aluop, ex_wsel} !== '0 || ex_portA !== 0 || ex_portB !== 0 || ex_store !== 0) begin
      errors++;
      $display("FAIL reset_state: valid=%b regwen=%b aluop=%h wsel=%h A=%h B=%h store=%h, required all 0",
               ex_valid, ex_regwen, ex_aluop, ex_wsel, ex_portA, ex_portB, ex_store);
    end
    nRST = 1;
    id_valid = 1; id_rs = 3; id_rdat1 = 32'h55; id_rt = 4; id_rdat2 = 32'h66;
    id_aluop = 4'h4; id_regwen = 1; id_wsel = 5'd6;
    tick();
    checks++;
    if (ex_valid !== 1 || ex_portA !== 32'h55 || ex_aluop !== 4'h4 || ex_wsel !== 5'd6 || ex_regwen !== 1) begin
      errors++;
      $display("FAIL first_load: valid=%b A=%h aluop=%h wsel=%h regwen=%b, required 1 00000055 4 06 1",
               ex_valid, ex_portA, ex_aluop, ex_wsel, ex_regwen);
    end
    // Asynchronous reset while stalled must clear the slot before any edge.
    stall = 1;
    #2 nRST = 0;
    #1;
    checks++;
    if (ex_valid !== 0 || ex_regwen !== 0 || ex_portA !== 0 || ex_portB !== 0 || ex_store !== 0 || ex_aluop !== 0) begin
      errors++;
      $display("FAIL async_reset: valid=%b regwen=%b A=%h B=%h store=%h aluop=%h, required all 0",
               ex_valid, ex_regwen, ex_portA, ex_portB, ex_store, ex_aluop);
    end
    tick();
    nRST = 1;
    stall = 0;
    tick();
    checks++;
    if (ex_valid !== 1 || ex_portA !== 32'h55 || ex_store !== 32'h66) begin
      errors++;
      $display("FAIL reload_after_reset: valid=%b A=%h store=%h, required 1 00000055 00000066",
               ex_valid, ex_portA, ex_store);
    end
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    id_valid = 1; id_rs = 5; id_rdat1 = 32'h1;
    exmem_wen = 1; exmem_wsel = 5; exmem_data = 32'hAAAA;
    memwb_wen = 1; memwb_wsel = 5; memwb_data = 32'hBBBB;
    tick();
    checks++;
    if (ex_portA !== 32'hAAAA) begin
      errors++;
      $display("FAIL fwd_exmem_wins: ex_portA=%h required 0000aaaa", ex_portA);
    end
    exmem_wen = 0;
    tick();
    checks++;
    if (ex_portA !== 32'hBBBB) begin
      errors++;
      $display("FAIL fwd_memwb: ex_portA=%h required 0000bbbb", ex_portA);
    end
    memwb_wen = 0;
    tick();
    checks++;
    if (ex_portA !== 32'h1) begin
      errors++;
      $display("FAIL fwd_regfile: ex_portA=%h required 00000001", ex_portA);
    end
    id_rs = 0; id_rt = 0; id_rdat1 = 32'hDEAD; id_rdat2 = 32'hBEEF;
    exmem_wen = 1; exmem_wsel = 0; memwb_wen = 1; memwb_wsel = 0;
    tick();
    checks++;
    if (ex_portA !== 0 || ex_store !== 0) begin
      errors++;
      $display("FAIL fwd_r0: ex_portA=%h ex_store=%h required 0 0", ex_portA, ex_store);
    end
  endtask

  task automatic test_immediates();
    bit [31:0] want [4] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'h00008001};
    idle_inputs();
    id_valid = 1; id_alusrc = 1; id_imm = 16'h8001;
    id_rt = 2; id_rdat2 = 32'h1357;
    for (int e = 0; e < 4; e++) begin
      id_extop = 2'(e);
      tick();
      checks++;
      if (ex_portB !== want[e] || ex_store !== 32'h1357) begin
        errors++;
        $display("FAIL imm_extop%0d: ex_portB=%h ex_store=%h required %h 00001357",
                 e, ex_portB, ex_store, want[e]);
      end
    end
  endtask

  task automatic test_shift();
    idle_inputs();
    id_valid = 1; id_shift = 1; id_shamt = 5'd31; id_rs = 7; id_rdat1 = 32'hDEAD;
    id_rt = 2; id_rdat2 = 32'h77; memwb_wen = 1; memwb_wsel = 2; memwb_data = 32'h99;
    tick();
    checks++;
    if (ex_portA !== 32'h1F || ex_portB !== 32'h99) begin
      errors++;
      $display("FAIL shift_operands: A=%h B=%h required 0000001f 00000099", ex_portA, ex_portB);
    end
  endtask

  task automatic test_stall_snoop();
    for (int src = 0; src < 2; src++) begin
      bit [31:0] b_load = src ? 32'h42 : 32'h10;
      bit [31:0] b_end  = src ? 32'h42 : 32'h1234;
      idle_inputs();
      id_valid = 1; id_rt = 9; id_rdat2 = 32'h10; id_alusrc = src[0]; id_imm = 16'h0042;
      tick();
      checks++;
      if (ex_portB !== b_load || ex_store !== 32'h10) begin
        errors++;
        $display("FAIL snoop_load_src%0d: B=%h store=%h required %h 00000010", src, ex_portB, ex_store, b_load);
      end
      stall = 1; id_rt = 3; id_rdat2 = 32'hFFFF; id_alusrc = 0;
      tick();
      checks++;
      if (ex_portB !== b_load || ex_store !== 32'h10) begin
        errors++;
        $display("FAIL snoop_hold_src%0d: B=%h store=%h required %h 00000010", src, ex_portB, ex_store, b_load);
      end
      memwb_wen = 1; memwb_wsel = 9; memwb_data = 32'h1234;
      tick();
      checks++;
      if (ex_portB !== b_end || ex_store !== 32'h1234 || ex_valid !== 1) begin
        errors++;
        $display("FAIL snoop_update_src%0d: B=%h store=%h valid=%b required %h 00001234 1",
                 src, ex_portB, ex_store, ex_valid, b_end);
      end
    end
  endtask

  task automatic test_flush_stall();
    idle_inputs();
    id_valid = 1; id_regwen = 1; id_wsel = 5'd12;
    tick();
    checks++;
    if (ex_valid !== 1 || ex_regwen !== 1) begin
      errors++;
      $display("FAIL flush_setup: valid=%b regwen=%b required 1 1", ex_valid, ex_regwen);
    end
    stall = 1; flush = 1;
    tick();
    checks++;
    if (ex_valid !== 0 || ex_regwen !== 0) begin
      errors++;
      $display("FAIL flush_over_stall: valid=%b regwen=%b required 0 0", ex_valid, ex_regwen);
    end
    stall = 0; flush = 0; id_valid = 0; id_regwen = 1;
    tick();
    checks++;
    if (ex_valid !== 0 || ex_regwen !== 0) begin
      errors++;
      $display("FAIL regwen_gated: valid=%b regwen=%b required 0 0", ex_valid, ex_regwen);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall      = ($urandom_range(0, 99) < 35);
      flush      = ($urandom_range(0, 99) < 8);
      id_valid   = ($urandom_range(0, 99) < 80);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_rdat1   = $urandom;
      id_rdat2   = $urandom;
      id_imm     = 16'($urandom);
      id_shamt   = 5'($urandom);
      id_alusrc  = 1'($urandom);
      id_extop   = 2'($urandom);
      id_shift   = ($urandom_range(0, 99) < 20);
      id_aluop   = 4'($urandom);
      id_regwen  = 1'($urandom);
      id_wsel    = 5'($urandom);
      exmem_wen  = 1'($urandom);
      exmem_wsel = 5'($urandom_range(0, 3));
      exmem_data = $urandom;
      memwb_wen  = 1'($urandom);
      memwb_wsel = 5'($urandom_range(0, 3));
      memwb_data = $urandom;
      tick();
      checks++;
      if (ex_valid !== m.valid || ex_regwen !== m.regwen) begin
        errors++;
        $display("FAIL rnd_ctrl cyc%0d: valid=%b regwen=%b required %b %b", cyc, ex_valid, ex_regwen, m.valid, m.regwen);
      end
      if (m.valid) begin
        checks++;
        if (ex_portA !== m.porta || ex_portB !== m.portb || ex_store !== m.store) begin
          errors++;
          $display("FAIL rnd_data cyc%0d: A=%h B=%h store=%h required %h %h %h",
                   cyc, ex_portA, ex_portB, ex_store, m.porta, m.portb, m.store);
        end
        checks++;
        if (ex_aluop !== m.aluop || ex_wsel !== m.wsel) begin
          errors++;
          $display("FAIL rnd_fields cyc%0d: aluop=%h wsel=%h required %h %h", cyc, ex_aluop, ex_wsel, m.aluop, m.wsel);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_immediates();
    test_shift();
    test_stall_snoop();
    test_flush_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
